// File: rtl/serial_tx_if.sv
// Byte hand-off into the serial transmitter: din is qualified by din_valid and accepted when din_ready is high.
interface serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/serial_tx.sv
// Async-serial frame transmitter: start, LSB-first data, even parity when SERIAL_TX_PARITY_EN is defined, stop.
// Registered tx falls the cycle after the handshake; din_ready is high only in IDLE, so a new byte waits out the whole frame.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    serial_tx_if.slave bus,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    state_t                state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_nxt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic                  tx_nxt;
    logic                  done_nxt;
    logic                  tick;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_q;
    logic                  parity_nxt;
`endif

    assign tick          = (div_cnt == DIV_LAST);
    assign busy          = (state != IDLE);
    assign bus.din_ready = (state == IDLE);

    always_comb begin
        state_nxt  = state;
        div_nxt    = div_cnt;
        bit_nxt    = bit_cnt;
        shreg_nxt  = shreg;
        done_nxt   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_nxt = parity_q;
`endif

        if (state != IDLE) begin
            div_nxt = tick ? '0 : div_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.din_valid) begin
                    shreg_nxt  = bus.din;
                    bit_nxt    = '0;
                    div_nxt    = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_nxt = ^bus.din;
`endif
                    state_nxt  = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Line level is chosen from the state being entered so tx changes on the same edge as the state.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_nxt = parity_q;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            tx       <= tx_nxt;
            done     <= done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

endmodule
